spi_master_core: RTL and testbench

SPI initiator (mode 0: CPOL=0, CPHA=0) that pairs with the SPI minion on the far side of the link. It accepts a parallel word on a val/rdy send stream, drives cs_n/sclk/mosi, samples miso, and returns the received word on a val/rdy recv stream. It sits between the on-chip requester and the pads, and generates sclk from the system clock with a programmable divider.

---
 rtl/spi_master_pkg.sv | 20 ++
 rtl/spi_master_sclk_gen.sv | 27 ++
 rtl/spi_master_core.sv | 127 ++++++++++++
 tb/tb_spi_master_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master core.
// State encodings, divider width and bit-counter sizing helper.
package spi_master_pkg;

    localparam int SCLK_DIV_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_SCLK_HIGH = 3'd2;
    localparam state_t ST_SCLK_LOW  = 3'd3;
    localparam state_t ST_DONE      = 3'd4;
    localparam state_t ST_RESP      = 3'd5;

    function automatic int bit_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_master_sclk_gen.sv
// Half-period counter for the SPI clock.
// Emits a one-cycle tick every div+1 cycles while not cleared.
module spi_master_sclk_gen
    import spi_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [SCLK_DIV_W-1:0] div,
    output logic                  tick
);

    logic [SCLK_DIV_W-1:0] cnt;

    assign tick = !clear && (cnt == div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + SCLK_DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master with val/rdy send and receive streams.
// Define SPI_MASTER_VAR_PACKET_SIZE_EN for a per-transfer packet_size port.
module spi_master_core
    import spi_master_pkg::*;
#(
    parameter int nbits    = 8,
    parameter int sclk_div = 1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_val,
    output logic                  send_rdy,
    input  logic [nbits-1:0]      send_msg,
`ifdef SPI_MASTER_VAR_PACKET_SIZE_EN
    input  logic [$clog2(nbits):0] packet_size,
`endif
    output logic                  recv_val,
    input  logic                  recv_rdy,
    output logic [nbits-1:0]      recv_msg,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int CW = bit_cnt_w(nbits);
    localparam logic [CW-1:0] NB = CW'(nbits);
    localparam logic [SCLK_DIV_W-1:0] DIV = SCLK_DIV_W'(sclk_div);

    state_t           state;
    logic [nbits-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             miso_bit;
    logic             tick;
    logic             clear;
    logic [CW-1:0]    load_cnt;
    logic [nbits-1:0] load_word;

`ifdef SPI_MASTER_VAR_PACKET_SIZE_EN
    // Short packets are left-aligned so the MSB-first shift is unchanged
    // and the vacated low zeros end up above the received bits.
    always_comb begin
        load_cnt  = NB;
        load_word = send_msg;
        if (packet_size != '0 && int'(packet_size) <= nbits) begin
            load_cnt  = CW'(packet_size);
            load_word = send_msg << (nbits - int'(packet_size));
        end
    end
`else
    assign load_cnt  = NB;
    assign load_word = send_msg;
`endif

    assign clear    = (state == ST_IDLE) || (state == ST_RESP);
    assign send_rdy = (state == ST_IDLE) && !reset;

    spi_master_sclk_gen u_sclk_gen (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .div   (DIV),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            recv_val <= 1'b0;
            recv_msg <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            miso_bit <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (send_val) begin
                        shreg   <= load_word;
                        bit_cnt <= load_cnt;
                        mosi    <= load_word[nbits-1];
                        cs_n    <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START, ST_SCLK_LOW: begin
                    if (tick) begin
                        sclk     <= 1'b1;
                        miso_bit <= miso;
                        state    <= ST_SCLK_HIGH;
                    end
                end
                ST_SCLK_HIGH: begin
                    if (tick) begin
                        sclk    <= 1'b0;
                        shreg   <= {shreg[nbits-2:0], miso_bit};
                        mosi    <= shreg[nbits-2];
                        bit_cnt <= bit_cnt - CW'(1);
                        state   <= (bit_cnt == CW'(1)) ? ST_DONE
                                                       : ST_SCLK_LOW;
                    end
                end
                ST_DONE: begin
                    if (tick) begin
                        recv_val <= 1'b1;
                        recv_msg <= shreg;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (recv_rdy) begin
                        recv_val <= 1'b0;
                        cs_n     <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: H=2 instance and H=1 instance.
// Loopback, minion model, back-pressure, mid-transfer reset, back-to-back.
module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] send_val, send_rdy, recv_val, recv_rdy;
    logic [1:0] cs_n, sclk, mosi, miso;
    logic [7:0] send_msg [2];
    logic [7:0] recv_msg [2];
`ifdef SPI_MASTER_VAR_PACKET_SIZE_EN
    logic [3:0] packet_size [2];
`endif

    logic       loop0;
    logic [7:0] minion_word;
    logic [7:0] mshr;
    logic       mbit;

    int n_checks = 0;
    int n_errors = 0;

    int          rises [2];
    int          viol  [2];
    int          per   [2];
    logic [15:0] mlog  [2];

    always #5 clk = ~clk;

    spi_master_core #(.nbits(8), .sclk_div(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .send_val    (send_val[0]),
        .send_rdy    (send_rdy[0]),
        .send_msg    (send_msg[0]),
`ifdef SPI_MASTER_VAR_PACKET_SIZE_EN
        .packet_size (packet_size[0]),
`endif
        .recv_val    (recv_val[0]),
        .recv_rdy    (recv_rdy[0]),
        .recv_msg    (recv_msg[0]),
        .cs_n        (cs_n[0]),
        .sclk        (sclk[0]),
        .mosi        (mosi[0]),
        .miso        (miso[0])
    );

    spi_master_core #(.nbits(8), .sclk_div(0)) u_fast (
        .clk         (clk),
        .reset       (reset),
        .send_val    (send_val[1]),
        .send_rdy    (send_rdy[1]),
        .send_msg    (send_msg[1]),
`ifdef SPI_MASTER_VAR_PACKET_SIZE_EN
        .packet_size (packet_size[1]),
`endif
        .recv_val    (recv_val[1]),
        .recv_rdy    (recv_rdy[1]),
        .recv_msg    (recv_msg[1]),
        .cs_n        (cs_n[1]),
        .sclk        (sclk[1]),
        .mosi        (mosi[1]),
        .miso        (miso[1])
    );

    assign mbit    = mshr[7];
    assign miso[0] = loop0 ? mosi[0] : mbit;
    assign miso[1] = mosi[1];

    // Mode-0 minion: first bit ready at select, next bit after each fall.
    always @(negedge cs_n[0]) mshr = minion_word;
    always @(negedge sclk[0]) if (!cs_n[0]) mshr = {mshr[6:0], 1'b0};

    for (genvar g = 0; g < 2; g++) begin : g_mon
        int   ncyc  = 0;
        int   lastr = 0;
        logic psclk = 1'b0;
        logic pmosi = 1'b0;
        initial begin
            rises[g] = 0;
            viol[g]  = 0;
            per[g]   = 0;
            mlog[g]  = '0;
        end
        always @(negedge clk) begin
            ncyc++;
            if (sclk[g] && mosi[g] !== pmosi) viol[g]++;
            if (sclk[g] && !psclk) begin
                rises[g]++;
                per[g]  = ncyc - lastr;
                lastr   = ncyc;
                mlog[g] = {mlog[g][14:0], mosi[g]};
            end
            psclk = sclk[g];
            pmosi = mosi[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int idx, input logic [7:0] word,
                        output logic [7:0] got, output int lat);
        @(negedge clk);
        check("send_rdy_pre", 32'(send_rdy[idx]), 32'd1);
        send_msg[idx] = word;
        send_val[idx] = 1'b1;
        @(posedge clk);
        #1 send_val[idx] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (recv_val[idx]) begin
                lat = k;
                break;
            end
        end
        got = recv_msg[idx];
    endtask

    logic [7:0] got;
    int         lat;
    int         r0;

    initial begin
        reset       = 1'b1;
        send_val    = '0;
        recv_rdy    = 2'b11;
        send_msg[0] = '0;
        send_msg[1] = '0;
        loop0       = 1'b1;
        minion_word = '0;
`ifdef SPI_MASTER_VAR_PACKET_SIZE_EN
        packet_size[0] = '0;
        packet_size[1] = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_send_rdy", 32'(send_rdy[0]), 32'd0);
        check("rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("rst_sclk", 32'(sclk[0]), 32'd0);
        check("rst_mosi", 32'(mosi[0]), 32'd0);
        check("rst_recv_val", 32'(recv_val[0]), 32'd0);
        check("rst_recv_msg", 32'(recv_msg[0]), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rdy0", 32'(send_rdy[0]), 32'd1);
        check("post_rst_rdy1", 32'(send_rdy[1]), 32'd1);

        // Loopback 0xA5
        r0 = rises[0];
        xfer(0, 8'hA5, got, lat);
        check("lb_msg", 32'(got), 32'hA5);
        check("lb_lat", 32'(lat), 32'd35);
        check("lb_rises", 32'(rises[0] - r0), 32'd8);
        check("lb_mosi_seq", 32'(mlog[0][7:0]), 32'hA5);
        check("lb_period", 32'(per[0]), 32'd4);
        check("lb_resp_cs", 32'(cs_n[0]), 32'd0);
        @(negedge clk);
        check("lb_resp_1cyc", 32'(recv_val[0]), 32'd0);
        check("lb_cs_release", 32'(cs_n[0]), 32'd1);

        // Minion returns 0x3C, consumer stalls
        loop0       = 1'b0;
        minion_word = 8'h3C;
        recv_rdy[0] = 1'b0;
        xfer(0, 8'hFF, got, lat);
        check("mn_msg", 32'(got), 32'h3C);
        check("mn_lat", 32'(lat), 32'd35);
        check("mn_mosi_seq", 32'(mlog[0][7:0]), 32'hFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            send_val[0] = (i == 3);
            send_msg[0] = 8'h55;
            check("hold_val", 32'(recv_val[0]), 32'd1);
            check("hold_msg", 32'(recv_msg[0]), 32'h3C);
            check("hold_cs", 32'(cs_n[0]), 32'd0);
            check("hold_rdy", 32'(send_rdy[0]), 32'd0);
        end
        send_val[0] = 1'b0;
        recv_rdy[0] = 1'b1;
        @(negedge clk);
        check("hold_release_val", 32'(recv_val[0]), 32'd0);
        check("hold_release_cs", 32'(cs_n[0]), 32'd1);
        @(negedge clk);
        check("hold_no_spurious", 32'(cs_n[0]), 32'd1);
        loop0 = 1'b1;

        // Reset after third rising edge
        r0 = rises[0];
        @(negedge clk);
        send_msg[0] = 8'hF0;
        send_val[0] = 1'b1;
        @(posedge clk);
        #1 send_val[0] = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rises[0] - r0 >= 3) break;
        end
        check("mid_rises", 32'(rises[0] - r0), 32'd3);
        check("mid_sclk_pre", 32'(sclk[0]), 32'd1);
        check("mid_mosi_pre", 32'(mosi[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_cs", 32'(cs_n[0]), 32'd1);
        check("mid_rst_sclk", 32'(sclk[0]), 32'd0);
        check("mid_rst_mosi", 32'(mosi[0]), 32'd0);
        check("mid_rst_msg", 32'(recv_msg[0]), 32'h0);
        check("mid_rst_rdy", 32'(send_rdy[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_post_rdy", 32'(send_rdy[0]), 32'd1);
        xfer(0, 8'h81, got, lat);
        check("mid_next_msg", 32'(got), 32'h81);
        check("mid_next_lat", 32'(lat), 32'd35);
        check("mid_next_seq", 32'(mlog[0][7:0]), 32'h81);

        // H=1, back-to-back 0x01 then 0x80
        r0 = rises[1];
        @(negedge clk);
        send_msg[1] = 8'h01;
        send_val[1] = 1'b1;
        @(posedge clk);
        #1 send_msg[1] = 8'h80;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (recv_val[1]) begin
                lat = k;
                break;
            end
        end
        check("b2b_lat0", 32'(lat), 32'd18);
        check("b2b_msg0", 32'(recv_msg[1]), 32'h01);
        @(negedge clk);
        check("b2b_gap_cs", 32'(cs_n[1]), 32'd1);
        check("b2b_gap_rdy", 32'(send_rdy[1]), 32'd1);
        @(posedge clk);
        #1 send_val[1] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (recv_val[1]) begin
                lat = k;
                break;
            end
        end
        check("b2b_lat1", 32'(lat), 32'd18);
        check("b2b_msg1", 32'(recv_msg[1]), 32'h80);
        check("b2b_rises", 32'(rises[1] - r0), 32'd16);
        check("b2b_period", 32'(per[1]), 32'd2);
        check("b2b_mosi_seq", 32'(mlog[1]), 32'h0180);

`ifdef SPI_MASTER_VAR_PACKET_SIZE_EN
        packet_size[0] = 4'd4;
        r0 = rises[0];
        xfer(0, 8'h0B, got, lat);
        check("ps4_msg", 32'(got), 32'h0B);
        check("ps4_lat", 32'(lat), 32'd19);
        check("ps4_rises", 32'(rises[0] - r0), 32'd4);
        check("ps4_seq", 32'(mlog[0][3:0]), 32'hB);
        packet_size[0] = 4'd0;
        r0 = rises[0];
        xfer(0, 8'h5A, got, lat);
        check("ps0_msg", 32'(got), 32'h5A);
        check("ps0_lat", 32'(lat), 32'd35);
        check("ps0_rises", 32'(rises[0] - r0), 32'd8);
`endif

        repeat (4) @(negedge clk);
        check("mosi_stable0", 32'(viol[0]), 32'd0);
        check("mosi_stable1", 32'(viol[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
